// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared definitions for the issue stage.
//   - Instruction/op/register/immediate widths.
//   - Decoded op codes for RV32I; OP_WOW marks an undecodable word.
//   - Op classification helpers (memory / branch / store).
//   - Issue-stage FSM state type.
package issue_ctrl_pkg;

  localparam int INS_LEN = 32;
  localparam int OP_LEN  = 6;
  localparam int REG_LEN = 5;
  localparam int IMM_LEN = 32;

  // OP_WOW is zero so a cleared issue register reads as "nothing valid".
  localparam logic [OP_LEN-1:0] OP_WOW   = 6'd0;
  localparam logic [OP_LEN-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_LEN-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_LEN-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_LEN-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_LEN-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_LEN-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_LEN-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_LEN-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_LEN-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_LEN-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_LEN-1:0] OP_LB    = 6'd11;
  localparam logic [OP_LEN-1:0] OP_LH    = 6'd12;
  localparam logic [OP_LEN-1:0] OP_LW    = 6'd13;
  localparam logic [OP_LEN-1:0] OP_LBU   = 6'd14;
  localparam logic [OP_LEN-1:0] OP_LHU   = 6'd15;
  localparam logic [OP_LEN-1:0] OP_SB    = 6'd16;
  localparam logic [OP_LEN-1:0] OP_SH    = 6'd17;
  localparam logic [OP_LEN-1:0] OP_SW    = 6'd18;
  localparam logic [OP_LEN-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_LEN-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_LEN-1:0] OP_SLTIU = 6'd21;
  localparam logic [OP_LEN-1:0] OP_XORI  = 6'd22;
  localparam logic [OP_LEN-1:0] OP_ORI   = 6'd23;
  localparam logic [OP_LEN-1:0] OP_ANDI  = 6'd24;
  localparam logic [OP_LEN-1:0] OP_SLLI  = 6'd25;
  localparam logic [OP_LEN-1:0] OP_SRLI  = 6'd26;
  localparam logic [OP_LEN-1:0] OP_SRAI  = 6'd27;
  localparam logic [OP_LEN-1:0] OP_ADD   = 6'd28;
  localparam logic [OP_LEN-1:0] OP_SUB   = 6'd29;
  localparam logic [OP_LEN-1:0] OP_SLL   = 6'd30;
  localparam logic [OP_LEN-1:0] OP_SLT   = 6'd31;
  localparam logic [OP_LEN-1:0] OP_SLTU  = 6'd32;
  localparam logic [OP_LEN-1:0] OP_XOR   = 6'd33;
  localparam logic [OP_LEN-1:0] OP_SRL   = 6'd34;
  localparam logic [OP_LEN-1:0] OP_SRA   = 6'd35;
  localparam logic [OP_LEN-1:0] OP_OR    = 6'd36;
  localparam logic [OP_LEN-1:0] OP_AND   = 6'd37;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_BLOCK = 2'd2
  } iss_state_e;

  // Loads and stores go to the load/store buffer; everything else to the RS.
  function automatic logic is_mem_op(input logic [OP_LEN-1:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_branch_op(input logic [OP_LEN-1:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

  function automatic logic is_store_op(input logic [OP_LEN-1:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

endpackage

// File: rtl/issue_ctrl_decode.sv
// issue_ctrl_decode: purely combinational RV32I decoder.
//   ins_in  : 32-bit instruction word
//   op_out  : decoded op code (OP_WOW when undecodable)
//   rd_out, rs1_out, rs2_out : raw register fields
//   imm_out : sign-extended immediate for the instruction format
module issue_ctrl_decode
  import issue_ctrl_pkg::*;
(
  input  logic [INS_LEN-1:0] ins_in,
  output logic [OP_LEN-1:0]  op_out,
  output logic [REG_LEN-1:0] rd_out,
  output logic [REG_LEN-1:0] rs1_out,
  output logic [REG_LEN-1:0] rs2_out,
  output logic [IMM_LEN-1:0] imm_out
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  always_comb begin
    opcode  = ins_in[6:0];
    f3      = ins_in[14:12];
    f7      = ins_in[31:25];
    op_out  = OP_WOW;
    rd_out  = ins_in[11:7];
    rs1_out = ins_in[19:15];
    rs2_out = ins_in[24:20];
    imm_out = '0;
    case (opcode)
      7'b0110111: begin
        op_out  = OP_LUI;
        imm_out = {ins_in[31:12], 12'b0};
      end
      7'b0010111: begin
        op_out  = OP_AUIPC;
        imm_out = {ins_in[31:12], 12'b0};
      end
      7'b1101111: begin
        op_out  = OP_JAL;
        imm_out = {{12{ins_in[31]}}, ins_in[19:12], ins_in[20], ins_in[30:21], 1'b0};
      end
      7'b1100111: begin
        if (f3 == 3'b000) op_out = OP_JALR;
        imm_out = {{20{ins_in[31]}}, ins_in[31:20]};
      end
      7'b1100011: begin
        case (f3)
          3'b000:  op_out = OP_BEQ;
          3'b001:  op_out = OP_BNE;
          3'b100:  op_out = OP_BLT;
          3'b101:  op_out = OP_BGE;
          3'b110:  op_out = OP_BLTU;
          3'b111:  op_out = OP_BGEU;
          default: op_out = OP_WOW;
        endcase
        imm_out = {{20{ins_in[31]}}, ins_in[7], ins_in[30:25], ins_in[11:8], 1'b0};
      end
      7'b0000011: begin
        case (f3)
          3'b000:  op_out = OP_LB;
          3'b001:  op_out = OP_LH;
          3'b010:  op_out = OP_LW;
          3'b100:  op_out = OP_LBU;
          3'b101:  op_out = OP_LHU;
          default: op_out = OP_WOW;
        endcase
        imm_out = {{20{ins_in[31]}}, ins_in[31:20]};
      end
      7'b0100011: begin
        case (f3)
          3'b000:  op_out = OP_SB;
          3'b001:  op_out = OP_SH;
          3'b010:  op_out = OP_SW;
          default: op_out = OP_WOW;
        endcase
        imm_out = {{20{ins_in[31]}}, ins_in[31:25], ins_in[11:7]};
      end
      7'b0010011: begin
        case (f3)
          3'b000:  op_out = OP_ADDI;
          3'b010:  op_out = OP_SLTI;
          3'b011:  op_out = OP_SLTIU;
          3'b100:  op_out = OP_XORI;
          3'b110:  op_out = OP_ORI;
          3'b111:  op_out = OP_ANDI;
          3'b001:  op_out = (f7 == 7'b0000000) ? OP_SLLI : OP_WOW;
          3'b101: begin
            if (f7 == 7'b0000000)      op_out = OP_SRLI;
            else if (f7 == 7'b0100000) op_out = OP_SRAI;
            else                       op_out = OP_WOW;
          end
          default: op_out = OP_WOW;
        endcase
        imm_out = {{20{ins_in[31]}}, ins_in[31:20]};
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  op_out = OP_ADD;
            3'b001:  op_out = OP_SLL;
            3'b010:  op_out = OP_SLT;
            3'b011:  op_out = OP_SLTU;
            3'b100:  op_out = OP_XOR;
            3'b101:  op_out = OP_SRL;
            3'b110:  op_out = OP_OR;
            default: op_out = OP_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  op_out = OP_SUB;
            3'b101:  op_out = OP_SRA;
            default: op_out = OP_WOW;
          endcase
        end
      end
      default: op_out = OP_WOW;
    endcase
  end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: issue-stage sequencer between the fetch queue and ROB/RS/LSB.
//   Fetch side : if_valid_in/if_ins_in/if_pc_in/if_pred_in, if_ready_out
//   Back end   : rob_full_in, rob_tail_in, rs_full_in, lsb_full_in, jalr_done_in
//   Issue side : iss_valid_out, iss_to_rs_out, iss_to_lsb_out, decoded fields,
//                iss_rob_idx_out (passes rob_tail_in), illegal_out
//   Control    : rdy_in freezes everything, clear_in flushes to EMPTY
// Optional macro ISSUE_STAT_EN adds stat_issued_out / stat_stall_out counters.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int ROB_IDX_W = 3,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic                 if_valid_in,
  input  logic [INS_LEN-1:0]   if_ins_in,
  input  logic [ADDR_W-1:0]    if_pc_in,
  input  logic                 if_pred_in,
  output logic                 if_ready_out,
  input  logic                 rob_full_in,
  input  logic [ROB_IDX_W-1:0] rob_tail_in,
  input  logic                 rs_full_in,
  input  logic                 lsb_full_in,
  input  logic                 jalr_done_in,
  output logic                 iss_valid_out,
  output logic                 iss_to_rs_out,
  output logic                 iss_to_lsb_out,
  output logic [OP_LEN-1:0]    iss_op_out,
  output logic [REG_LEN-1:0]   iss_rd_out,
  output logic [REG_LEN-1:0]   iss_rs1_out,
  output logic [REG_LEN-1:0]   iss_rs2_out,
  output logic [IMM_LEN-1:0]   iss_imm_out,
  output logic [ADDR_W-1:0]    iss_pc_out,
  output logic                 iss_pred_out,
  output logic [ROB_IDX_W-1:0] iss_rob_idx_out,
  output logic                 illegal_out
`ifdef ISSUE_STAT_EN
  ,
  output logic [31:0]          stat_issued_out,
  output logic [31:0]          stat_stall_out
`endif
);

  iss_state_e         state_q, state_d;
  logic [OP_LEN-1:0]  op_q, op_d;
  logic [REG_LEN-1:0] rd_q, rd_d;
  logic [REG_LEN-1:0] rs1_q, rs1_d;
  logic [REG_LEN-1:0] rs2_q, rs2_d;
  logic [IMM_LEN-1:0] imm_q, imm_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pred_q, pred_d;

  logic [OP_LEN-1:0]  dec_op;
  logic [REG_LEN-1:0] dec_rd, dec_rs1, dec_rs2;
  logic [IMM_LEN-1:0] dec_imm;

  logic is_mem, is_wow, is_jalr, tgt_full, active;
  logic fire, illegal, if_ready, accept;

  issue_ctrl_decode u_decode (
    .ins_in  (if_ins_in),
    .op_out  (dec_op),
    .rd_out  (dec_rd),
    .rs1_out (dec_rs1),
    .rs2_out (dec_rs2),
    .imm_out (dec_imm)
  );

  // Handshake / firing. Gated with !rst_in so every strobe reads 0 while in reset.
  always_comb begin
    active   = rdy_in && !rst_in && !clear_in;
    is_mem   = is_mem_op(op_q);
    is_wow   = (op_q == OP_WOW);
    is_jalr  = (op_q == OP_JALR);
    // Only the queue the held op targets can block it.
    tgt_full = is_mem ? lsb_full_in : rs_full_in;
    fire     = active && (state_q == ST_FULL) && !is_wow && !rob_full_in && !tgt_full;
    illegal  = active && (state_q == ST_FULL) && is_wow;
    // A firing non-JALR frees the register in the same cycle for back-to-back issue.
    if_ready = active && ((state_q == ST_EMPTY) || (fire && !is_jalr));
    accept   = if_ready && if_valid_in;
  end

  // Next state and issue register.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    pred_d  = pred_q;

    if (rdy_in) begin
      if (clear_in) begin
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: if (accept) state_d = ST_FULL;
          ST_FULL: begin
            if (is_wow)               state_d = ST_EMPTY;
            else if (fire && is_jalr) state_d = ST_BLOCK;
            else if (fire)            state_d = accept ? ST_FULL : ST_EMPTY;
          end
          ST_BLOCK: if (jalr_done_in) state_d = ST_EMPTY;
          default:  state_d = ST_EMPTY;
        endcase
      end

      if (accept) begin
        op_d   = dec_op;
        // Branches and stores write no register; their rd field holds immediate bits.
        rd_d   = (is_branch_op(dec_op) || is_store_op(dec_op)) ? '0 : dec_rd;
        rs1_d  = dec_rs1;
        rs2_d  = dec_rs2;
        imm_d  = dec_imm;
        pc_d   = if_pc_in;
        pred_d = if_pred_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_EMPTY;
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pred_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      pred_q  <= pred_d;
    end
  end

  assign if_ready_out    = if_ready;
  assign iss_valid_out   = fire;
  assign iss_to_lsb_out  = fire && is_mem;
  assign iss_to_rs_out   = fire && !is_mem;
  assign illegal_out     = illegal;
  assign iss_op_out      = op_q;
  assign iss_rd_out      = rd_q;
  assign iss_rs1_out     = rs1_q;
  assign iss_rs2_out     = rs2_q;
  assign iss_imm_out     = imm_q;
  assign iss_pc_out      = pc_q;
  assign iss_pred_out    = pred_q;
  assign iss_rob_idx_out = rob_tail_in;

`ifdef ISSUE_STAT_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (rdy_in) begin
      if (fire) stat_issued_d = stat_issued_q + 32'd1;
      if (((state_q == ST_FULL) && !fire) || (state_q == ST_BLOCK))
        stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued_out = stat_issued_q;
  assign stat_stall_out  = stat_stall_q;
`endif

endmodule
